// File: rtl/alarm_sched_if.sv
// alarm_sched_if: bundles the slot-write, acknowledge and compare-unit signals of alarm_sched.
//   wr_en_i/wr_slot_i/wr_ts_i/wr_arm_i : slot programming (one write per cycle)
//   ack_i/ack_slot_i                   : clear one pending flag
//   match_i                            : registered equality result from the compare unit
//   cmp_ts_o                           : timestamp presented to the compare unit
//   armed_o/pend_o/irq_o               : per-slot status and interrupt
// The slave modport is the scheduler's view; master is the view of whatever drives it.
interface alarm_sched_if #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned TS_W    = 43
);
    localparam int unsigned SW = $clog2(N_SLOTS);

    logic               wr_en_i;
    logic [SW-1:0]      wr_slot_i;
    logic [TS_W-1:0]    wr_ts_i;
    logic               wr_arm_i;
    logic               ack_i;
    logic [SW-1:0]      ack_slot_i;
    logic               match_i;
    logic [TS_W-1:0]    cmp_ts_o;
    logic [N_SLOTS-1:0] armed_o;
    logic [N_SLOTS-1:0] pend_o;
    logic               irq_o;

    modport slave (
        input  wr_en_i, wr_slot_i, wr_ts_i, wr_arm_i, ack_i, ack_slot_i, match_i,
        output cmp_ts_o, armed_o, pend_o, irq_o
    );

    modport master (
        output wr_en_i, wr_slot_i, wr_ts_i, wr_arm_i, ack_i, ack_slot_i, match_i,
        input  cmp_ts_o, armed_o, pend_o, irq_o
    );
endinterface

// File: rtl/alarm_sched.sv
// alarm_sched: round-robin alarm scheduler sharing one external timestamp comparator.
// Each slot stores a packed timestamp and an armed flag. The FSM walks the armed slots,
// presenting each timestamp for two cycles (LOAD, CHECK); the comparator's registered
// result is sampled at the end of CHECK and fires the slot once (pending set, armed cleared).
// Ports:
//   clk_i  : clock, rising edge
//   rstn_i : asynchronous active-low reset
//   bus    : alarm_sched_if slave modport (writes, acks, match in; cmp_ts, armed, pend, irq out)
module alarm_sched #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned TS_W    = 43
) (
    input logic         clk_i,
    input logic         rstn_i,
    alarm_sched_if.slave bus
);
    localparam int unsigned SW = $clog2(N_SLOTS);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic               discard_q, discard_d;
    logic [TS_W-1:0]    ts_q [N_SLOTS];
    logic [N_SLOTS-1:0] armed_q, armed_d;
    logic [N_SLOTS-1:0] pend_q, pend_d;
    logic               irq_q;

    logic [TS_W-1:0]    cmp_ts;
    logic               wr_hit;
    logic               fire;
    logic [SW-1:0]      lowest;
    logic [SW-1:0]      rr_next;
    logic               rr_found;
    logic [SW-1:0]      cand;

    // A write to the slot under scan invalidates the comparator result for this pass.
    assign wr_hit = bus.wr_en_i && (bus.wr_slot_i == slot_q);
    assign fire   = (state_q == StCheck) && bus.match_i && armed_q[slot_q]
                    && !discard_q && !wr_hit;

    // Armed and pending next-state; the write (same slot) never coincides with fire.
    always_comb begin
        armed_d = armed_q;
        if (fire) armed_d[slot_q] = 1'b0;
        if (bus.wr_en_i) armed_d[bus.wr_slot_i] = bus.wr_arm_i;

        pend_d = pend_q;
        if (bus.ack_i) pend_d[bus.ack_slot_i] = 1'b0;
        if (fire) pend_d[slot_q] = 1'b1; // set wins over a simultaneous ack
    end

    // Lowest-index armed slot, used when leaving IDLE.
    always_comb begin
        lowest = '0;
        for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
            if (armed_q[i]) lowest = SW'(i);
        end
    end

    // Round-robin successor from slot_q+1 upward, slot_q itself last. Descending offsets
    // so the nearest candidate is assigned last. Uses post-update flags so a slot that
    // just fired or was disarmed is not revisited.
    always_comb begin
        rr_next  = slot_q;
        rr_found = 1'b0;
        cand     = slot_q;
        for (int i = int'(N_SLOTS); i >= 1; i--) begin
            cand = slot_q + SW'(i);
            if (armed_d[cand]) begin
                rr_next  = cand;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        discard_d = discard_q;
        cmp_ts    = '1; // sec=63 never matches a real time
        case (state_q)
            StIdle: begin
                if (|armed_q) begin
                    state_d = StLoad;
                    slot_d  = lowest;
                end
            end
            StLoad: begin
                cmp_ts  = ts_q[slot_q];
                state_d = StCheck;
                if (wr_hit) discard_d = 1'b1;
            end
            StCheck: begin
                cmp_ts    = ts_q[slot_q];
                discard_d = 1'b0;
                if (rr_found) begin
                    state_d = StLoad;
                    slot_d  = rr_next;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            slot_q    <= '0;
            discard_q <= 1'b0;
            armed_q   <= '0;
            pend_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            discard_q <= discard_d;
            armed_q   <= armed_d;
            pend_q    <= pend_d;
            irq_q     <= |pend_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < int'(N_SLOTS); i++) ts_q[i] <= '1;
        end else if (bus.wr_en_i) begin
            ts_q[bus.wr_slot_i] <= bus.wr_ts_i;
        end
    end

    assign bus.cmp_ts_o = cmp_ts;
    assign bus.armed_o  = armed_q;
    assign bus.pend_o   = pend_q;
    assign bus.irq_o    = irq_q;
endmodule

// File: tb/tb_alarm_sched.sv
// tb_alarm_sched: directed bench for alarm_sched with a registered-compare model of the
// external comparator (match = cmp_ts_o == cur_time, one cycle late). Outputs are sampled
// 1 time unit after the rising edge.
module tb_alarm_sched;
    localparam int unsigned N  = 4;
    localparam int unsigned TW = 43;

    localparam logic [TW-1:0] ONES = '1;
    localparam logic [TW-1:0] TA   = 43'h11_1111_1101;
    localparam logic [TW-1:0] TB   = 43'h22_2222_2202;
    localparam logic [TW-1:0] TC   = 43'h33_3333_3303;
    localparam logic [TW-1:0] TD   = 43'h44_4444_4404;
    localparam logic [TW-1:0] T2   = 43'h55_5555_5505;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [TW-1:0] cur_time = '0;
    logic          match_q;
    logic          force_m = 1'b0;
    int            n_total = 0;
    int            n_bad = 0;

    alarm_sched_if #(.N_SLOTS(N), .TS_W(TW)) bus ();

    alarm_sched #(.N_SLOTS(N), .TS_W(TW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) match_q <= 1'b0;
        else       match_q <= (bus.cmp_ts_o == cur_time);
    end
    assign bus.match_i = match_q | force_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int s, input logic [TW-1:0] ts, input logic arm);
        bus.wr_en_i   = 1'b1;
        bus.wr_slot_i = 2'(s);
        bus.wr_ts_i   = ts;
        bus.wr_arm_i  = arm;
        tick();
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic ack(input int s);
        bus.ack_i      = 1'b1;
        bus.ack_slot_i = 2'(s);
        tick();
        bus.ack_i      = 1'b0;
    endtask

    // Tick until (cmp_ts_o == v) equals eq, bounded.
    task automatic wait_cmp(input logic [TW-1:0] v, input logic eq, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((bus.cmp_ts_o == v) == eq) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_pend(input logic [N-1:0] mask, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if ((bus.pend_o & mask) == mask) break;
            tick();
        end
        check(tag, 64'(bus.pend_o & mask), 64'(mask));
    endtask

    initial begin
        logic [TW-1:0] seq [8];
        seq = '{TA, TA, TB, TB, TC, TC, TA, TA};
        bus.wr_en_i = 1'b0; bus.wr_slot_i = '0; bus.wr_ts_i = '0; bus.wr_arm_i = 1'b0;
        bus.ack_i = 1'b0; bus.ack_slot_i = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmp", 64'(bus.cmp_ts_o), 64'(ONES));
        check("rst_armed", 64'(bus.armed_o), 64'd0);
        @(negedge clk) rstn = 1'b1;
        tick();
        check("rst_pend", 64'(bus.pend_o), 64'd0);
        check("rst_irq", 64'(bus.irq_o), 64'd0);
        check("rst_cmp2", 64'(bus.cmp_ts_o), 64'(ONES));

        // Single alarm on slot 2 fires, irq one cycle later, ack clears
        cur_time = T2;
        wr(2, T2, 1'b1);
        check("t1_armed", 64'(bus.armed_o), 64'h4);
        wait_pend(4'b0100, 9, "t1_fire");
        check("t1_pend", 64'(bus.pend_o), 64'h4);
        check("t1_disarm", 64'(bus.armed_o), 64'h0);
        check("t1_irq_lag", 64'(bus.irq_o), 64'd0);
        tick();
        check("t1_irq", 64'(bus.irq_o), 64'd1);
        check("t1_idle", 64'(bus.cmp_ts_o), 64'(ONES));
        ack(2);
        check("t1_ack", 64'(bus.pend_o), 64'h0);
        tick();
        check("t1_irq_clr", 64'(bus.irq_o), 64'd0);
        cur_time = '0;

        // Scan order 0,0,1,1,3,3,0,0 with slot 2 skipped
        wr(0, TA, 1'b1);
        wr(1, TB, 1'b1);
        wr(3, TC, 1'b1);
        wait_cmp(TC, 1'b1, "t2_sync_a");
        wait_cmp(TC, 1'b0, "t2_sync_b");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_seq%0d", i), 64'(bus.cmp_ts_o), 64'(seq[i]));
            tick();
        end
        wr(0, TA, 1'b0);
        wr(1, TB, 1'b0);
        wr(3, TC, 1'b0);
        repeat (4) tick();
        check("t2_armed0", 64'(bus.armed_o), 64'h0);
        check("t2_idle", 64'(bus.cmp_ts_o), 64'(ONES));

        // Two slots with the same time both fire within one scan
        wr(1, TC, 1'b1);
        wr(3, TC, 1'b1);
        cur_time = TC;
        wait_pend(4'b1010, 12, "t3_fire");
        check("t3_pend", 64'(bus.pend_o), 64'ha);
        check("t3_armed", 64'(bus.armed_o), 64'h0);
        tick();
        check("t3_irq", 64'(bus.irq_o), 64'd1);
        ack(1);
        ack(3);
        check("t3_ack", 64'(bus.pend_o), 64'h0);
        cur_time = '0;

        // Rewrite slot 1 during its CHECK while match_i=1
        wr(0, TA, 1'b1);
        wr(1, TB, 1'b1);
        wait_cmp(TA, 1'b1, "t4_sync_a");
        wait_cmp(TA, 1'b0, "t4_sync_b");
        check("t4_load1", 64'(bus.cmp_ts_o), 64'(TB));
        cur_time = TB;
        tick();
        check("t4_match", 64'(bus.match_i), 64'd1);
        wr(1, TD, 1'b1);
        check("t4_nopend", 64'(bus.pend_o), 64'h0);
        check("t4_armed", 64'(bus.armed_o), 64'h3);
        wait_cmp(TA, 1'b1, "t4_sync_c");
        wait_cmp(TA, 1'b0, "t4_sync_d");
        check("t4_newts", 64'(bus.cmp_ts_o), 64'(TD));
        repeat (4) tick();
        check("t4_nopend2", 64'(bus.pend_o), 64'h0);

        // Write to slot 0 during its LOAD discards that pass only
        cur_time = '0;
        wait_cmp(TD, 1'b1, "t5_sync_a");
        wait_cmp(TD, 1'b0, "t5_sync_b");
        cur_time = TA;
        wr(0, TA, 1'b1);
        tick();
        check("t5_discard", 64'(bus.pend_o), 64'h0);
        wait_pend(4'b0001, 10, "t5_fire_next");
        check("t5_armed", 64'(bus.armed_o), 64'h2);
        ack(0);
        cur_time = '0;

        // Ack in the same cycle the match is recorded: set wins; then disarm all
        wr(0, TA, 1'b1);
        wait_cmp(TD, 1'b1, "t6_sync_a");
        wait_cmp(TD, 1'b0, "t6_sync_b");
        cur_time = TA;
        tick();
        bus.ack_i      = 1'b1;
        bus.ack_slot_i = 2'd0;
        tick();
        bus.ack_i      = 1'b0;
        check("t6_setwins", 64'(bus.pend_o), 64'h1);
        wr(1, TD, 1'b0);
        repeat (4) tick();
        check("t6_armed0", 64'(bus.armed_o), 64'h0);
        check("t6_idle", 64'(bus.cmp_ts_o), 64'(ONES));
        ack(0);
        cur_time = '0;
        repeat (2) tick();

        // Reset during CHECK with match_i=1
        wr(2, TC, 1'b1);
        wait_cmp(ONES, 1'b0, "t7_sync");
        tick();
        force_m = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check("t7_cmp", 64'(bus.cmp_ts_o), 64'(ONES));
        check("t7_armed", 64'(bus.armed_o), 64'h0);
        check("t7_pend", 64'(bus.pend_o), 64'h0);
        check("t7_irq", 64'(bus.irq_o), 64'd0);
        tick();
        force_m = 1'b0;
        @(negedge clk) rstn = 1'b1;
        tick();
        check("t7_pend_after", 64'(bus.pend_o), 64'h0);
        check("t7_armed_after", 64'(bus.armed_o), 64'h0);
        check("t7_cmp_after", 64'(bus.cmp_ts_o), 64'(ONES));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/alarm_sched.md
ALARM_SCHED -- requirements
Module: alarm_sched

Interface
REQ-001 Parameter N_SLOTS, default 4, number of alarm slots; power of two, 2..8.
REQ-002 Parameter TS_W, default 43, packed timestamp width {year[11:0],month[3:0],day_of_month[4:0],day_of_week[2:0],mode[1:0],hour[4:0],min[5:0],sec[5:0]}, MSB first.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 wr_en_i  in  1  slot write strobe, one write per cycle.
REQ-006 wr_slot_i  in  log2(N_SLOTS)  slot index for write.
REQ-007 wr_ts_i  in  TS_W  alarm timestamp to store.
REQ-008 wr_arm_i  in  1  1 = arm slot on write, 0 = disarm slot.
REQ-009 ack_i  in  1  pending-clear strobe.
REQ-010 ack_slot_i  in  log2(N_SLOTS)  slot whose pending flag is cleared.
REQ-011 match_i  in  1  registered equality result from the compare unit, valid one cycle after cmp_ts_o is presented.
REQ-012 cmp_ts_o  out  TS_W  timestamp driven to the compare unit.
REQ-013 armed_o  out  N_SLOTS  per-slot armed flags.
REQ-014 pend_o  out  N_SLOTS  per-slot pending (fired) flags.
REQ-015 irq_o  out  1  registered OR of pend_o.

Function
REQ-016 Each slot holds a TS_W timestamp register and an armed flag; a write updates both for wr_slot_i at the next edge.
REQ-017 FSM states: IDLE, LOAD, CHECK.
REQ-018 IDLE: cmp_ts_o = all ones (sec=63, never matches); move to LOAD when any armed flag is 1, selecting the lowest-index armed slot.
REQ-019 LOAD: cmp_ts_o = timestamp of current slot k; always go to CHECK next cycle.
REQ-020 CHECK: cmp_ts_o still = slot k; at the end of CHECK, if match_i=1 and slot k still armed, set pend[k]=1 and clear armed[k] (one-shot).
REQ-021 After CHECK: select next armed slot searching k+1 upward with wrap-around (round robin), including k itself last; go to LOAD; if none armed, go to IDLE.
REQ-022 Full scan latency: 2 cycles per armed slot; a match is recorded at most 2*N_SLOTS+1 cycles after the time value becomes equal.
REQ-023 Write to slot k in the same cycle as CHECK of slot k: match result discarded, write takes effect, no pend set.
REQ-024 Write to slot k during its LOAD: CHECK of that pass is also discarded (flag recorded, cleared after CHECK).
REQ-025 Disarm of the only armed slot: FSM completes current state then goes to IDLE.
REQ-026 Writing a new armed timestamp to a slot does not clear its pending flag.
REQ-027 ack_i clears pend[ack_slot_i] at next edge; simultaneous set and ack of same slot: set wins.
REQ-028 irq_o updates one cycle after pend_o changes.
REQ-029 match_i ignored in IDLE and LOAD.

Reset
REQ-030 On rstn_i low: FSM=IDLE, all timestamps all ones, armed_o=0, pend_o=0, irq_o=0, cmp_ts_o=all ones, internal slot index 0, discard flag 0.
REQ-031 Reset asserted mid-scan aborts immediately; no pend set for the in-flight CHECK.

Verification
REQ-032 Arm slot 2 with T, compare unit model matches at T -> within 9 cycles pend_o=4'b0100, armed_o[2]=0, irq_o=1 one cycle later; ack slot 2 -> pend_o=0, irq_o=0.
REQ-033 Arm slots 0,1,3 with distinct times; observe cmp_ts_o sequence 0,0,1,1,3,3,0,0 (2 cycles each), slot 2 skipped.
REQ-034 Slots 1 and 3 same timestamp T, time reaches T -> both pend bits set within one scan, irq_o=1.
REQ-035 Rewrite slot 1 during its CHECK while match_i=1 -> pend_o[1]=0, new timestamp presented next pass.
REQ-036 Ack slot 0 in same cycle its match is recorded -> pend_o[0]=1; disarm all slots -> FSM IDLE, cmp_ts_o=all ones.
REQ-037 Assert rstn_i low during CHECK with match_i=1 -> all outputs reset values, no pending flag set.
